uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter peripheral. It is a bus responder on the SoC data bus, next to faccel, gpio and FPWrapper.
//  The MIPS core writes bytes into a TX FIFO; the block serialises them 8N1, LSB first, on tx.
//  It raises irq when the FIFO drains, feeding the SoC done/interrupt OR alongside faccel_done/FPM_done.
//  The SoC address decoder drives WE for this block; readback goes through the SoC read mux.
// PARAMETERS
//  DEPTH        8   FIFO entries; power of 2, >=2
//  DIV_DEFAULT  16  BAUDDIV reset value (clocks per bit)
// PORTS
//  clk   in   1   system clock; all state on posedge
//  rst   in   1   asynchronous, active-low reset
//  WE    in   1   bus write strobe, already address-decoded by SoC
//  A     in   2   word offset, dataadr[3:2]
//  WD    in   32  bus write data
//  RD    out  32  bus read data; combinational from A and registers
//  tx    out  1   serial line; idles high
//  irq   out  1   level interrupt = irq_pend & irq_en
// BEHAVIOUR
//  Register map:
//   A=0 TXDATA  (W) push WD[7:0]. Read returns 0.
//   A=1 STATUS  (R) {27'b0, ovf, irq_pend, busy, full, empty}.
//               (W) write-1-to-clear, WD[4]=ovf, WD[3]=irq_pend; other bits ignored.
//   A=2 CTRL    (R/W) [0]=en, [1]=irq_en; other bits read 0.
//   A=3 BAUDDIV (R/W) [15:0] clocks per bit; value 0 is treated as 1.
//  Reset values: tx=1, irq=0, FIFO empty, state IDLE, en=0, irq_en=0, ovf=0, irq_pend=0, BAUDDIV=DIV_DEFAULT.
//  Reset mid-frame: tx returns high immediately; FIFO contents are lost.
//  Push rule:
//   - A TXDATA write is accepted iff count<DEPTH, using the count registered at the start of the cycle.
//   - Push onto a full FIFO is dropped and sets ovf, even if a pop happens in the same cycle.
//  Pop: push and pop in the same cycle on a non-full FIFO leaves count unchanged.
//  FSM IDLE -> START -> DATA -> STOP -> (START | IDLE):
//   IDLE:  tx=1. When en & !empty: pop head into shift reg, latch div = max(BAUDDIV,1), bit_cnt=0, go to START next cycle.
//   START: tx=0 for div clocks.
//   DATA:  tx=shift[0] for div clocks; then shift right, bit_cnt++; after bit 7 go to STOP.
//   STOP:  tx=1 for div clocks. At the end:
//          - if en & !empty: pop and go directly to START (back-to-back frames, no idle gap);
//          - otherwise go to IDLE and set irq_pend if empty.
//  Frame length = 10*div clocks.
//  busy = (state != IDLE).
//  BAUDDIV or en changed mid-frame: the current frame completes with the latched div.
//   - Clearing en stops further pops only.
//  Simultaneous set and W1C clear of irq_pend in one cycle: set wins.
//  Bit timer: 16-bit down-counter loaded with div-1 at each bit start; the bit ends when it reaches 0.
// STRUCTURE
//  Shared header uart_tx_defs.vh holds:
//   - offsets TXDATA=2'd0, STATUS=2'd1, CTRL=2'd2, BAUDDIV=2'd3;
//   - state encodings S_IDLE/S_START/S_DATA/S_STOP;
//   - STATUS bit indices.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH):
//   - ports: clk, rst, push, pop, din, dout, empty, full;
//   - show-ahead dout; wrap-around pointers with an extra bit for full/empty.
//  Top level holds the register file, read mux, FSM, bit timer and shift register.
// TESTING
//  1. Reset, write BAUDDIV=4, CTRL=1, TXDATA=0xA5.
//     -> tx = 0, then 1,0,1,0,0,1,0,1, then 1; each level 4 clks; frame 40 clks; busy=1 throughout.
//  2. CTRL=0, write 9 bytes 0x00..0x08 (DEPTH=8).
//     -> STATUS full=1, ovf=1; byte 0x08 dropped; write STATUS=0x10 -> ovf=0.
//     -> Set CTRL=3: bytes 0x00..0x07 are sent back-to-back with no idle gap.
//  3. CTRL=3, BAUDDIV=2, send 0x55.
//     -> after the stop bit irq=1, STATUS=0x09.
//     -> Write STATUS=0x08 -> irq=0. With irq_en=0, irq stays 0 while irq_pend=1.
//  4. BAUDDIV=0, send 0xFF.
//     -> each bit is 1 clk, frame 10 clks.
//     -> Change BAUDDIV to 8 mid-frame: current frame still 10 clks, next frame 80 clks.
//  5. Assert rst low mid-DATA.
//     -> tx=1 and irq=0 with no clock edge; after release STATUS=0x01 and BAUDDIV reads 16.
//  6. Push while a pop occurs (FIFO count 3) -> count stays 3 and byte order is preserved.
//     Disable en mid-frame -> the frame finishes, then IDLE with the FIFO retained.

Source files
------------

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets,
// STATUS bit positions, FSM state encoding and the divider clamp helper.
package uart_tx_periph_pkg;

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_BAUDDIV = 2'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_IRQ   = 3;
    localparam int ST_OVF   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // A programmed divider of 0 behaves as 1 clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate count register.
module sync_fifo
    import uart_tx_periph_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, read mux, TX FIFO,
// frame FSM with a per-bit down-counter, and drain interrupt.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int DIV_DEFAULT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        irq
);

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        ovf_q, ovf_d;
    logic        irq_pend_q, irq_pend_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] div_q, div_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;

    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [7:0]  fifo_dout;
    logic        wr_txdata, wr_status, wr_ctrl, wr_baud;
    logic        bit_done, busy, irq_set;
    logic        unused_wd;

    assign wr_txdata = WE && (A == ADDR_TXDATA);
    assign wr_status = WE && (A == ADDR_STATUS);
    assign wr_ctrl   = WE && (A == ADDR_CTRL);
    assign wr_baud   = WE && (A == ADDR_BAUDDIV);
    assign fifo_push = wr_txdata && !fifo_full;
    assign bit_done  = (timer_q == 16'd0);
    assign busy      = (state_q != S_IDLE);
    assign irq       = irq_pend_q && irq_en_q;
    assign unused_wd = ^WD[31:16];

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (WD[7:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // tx is decoded from state so an asynchronous reset forces it high at once.
    always_comb begin
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        timer_d   = timer_q;
        fifo_pop  = 1'b0;
        irq_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    div_d     = eff_div(baud_q);
                    timer_d   = eff_div(baud_q) - 16'd1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    timer_d = div_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_d   = div_q - 16'd1;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STOP: begin
                if (!bit_done) begin
                    timer_d = timer_q - 16'd1;
                end else if (en_q && !fifo_empty) begin
                    // Next frame starts with no idle gap and picks up the current divider.
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    div_d     = eff_div(baud_q);
                    timer_d   = eff_div(baud_q) - 16'd1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_START;
                end else begin
                    irq_set = fifo_empty;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags: a set in the same cycle as a write-1-to-clear wins.
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        baud_d     = baud_q;
        ovf_d      = ovf_q;
        irq_pend_d = irq_pend_q;
        if (wr_ctrl) begin
            en_d     = WD[0];
            irq_en_d = WD[1];
        end
        if (wr_baud) begin
            baud_d = WD[15:0];
        end
        if (wr_status && WD[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (wr_status && WD[ST_IRQ]) begin
            irq_pend_d = 1'b0;
        end
        if (irq_set) begin
            irq_pend_d = 1'b1;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (A)
            ADDR_STATUS: begin
                RD[ST_EMPTY] = fifo_empty;
                RD[ST_FULL]  = fifo_full;
                RD[ST_BUSY]  = busy;
                RD[ST_IRQ]   = irq_pend_q;
                RD[ST_OVF]   = ovf_q;
            end
            ADDR_CTRL:    RD[1:0]  = {irq_en_q, en_q};
            ADDR_BAUDDIV: RD[15:0] = baud_q;
            default:      RD = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            baud_q     <= 16'(DIV_DEFAULT);
            div_q      <= 16'd1;
            timer_q    <= 16'd0;
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            irq_pend_q <= irq_pend_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: directed bus traffic, expected frames queued as
// {b2b, div, byte} and checked by an independent serial-line monitor.
module tb_uart_tx_periph;

    localparam logic [1:0] A_TX   = 2'd0;
    localparam logic [1:0] A_ST   = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_BAUD = 2'd3;

    logic        clk, rst_n, WE, tx, irq;
    logic [1:0]  A;
    logic [31:0] WD, RD;

    int checks   = 0;
    int failures = 0;

    // Entry layout: [24] must follow previous frame with no gap, [23:8] div, [7:0] byte.
    logic [24:0] exp_q[$];
    logic        mon_on;
    logic        mon_busy;

    uart_tx_periph #(.DEPTH(8), .DIV_DEFAULT(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .WE  (WE),
        .A   (A),
        .WD  (WD),
        .RD  (RD),
        .tx  (tx),
        .irq (irq)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        A  = a;
        WD = d;
        WE = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        A = a;
        #1;
        check(name, RD, exp);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [15:0] div, input logic b2b);
        exp_q.push_back({b2b, div, d});
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        A = A_ST;
        @(negedge clk);
        while ((exp_q.size() != 0 || mon_busy || RD[2]) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("FAIL %s_drain got=%0d cycles required<%0d", tag, n, max_cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        int          gap;
        int          div;
        int          errs;
        logic [24:0] e;
        logic [7:0]  got;
        logic        lvl;
        gap      = 1;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_on || tx !== 1'b0) begin
                gap++;
            end else if (exp_q.size() == 0) begin
                mon_busy = 1'b1;
                checks++;
                failures++;
                $display("FAIL unexpected_frame got=start_bit required=idle_line");
                for (int n = 0; n < 2000 && tx !== 1'b1; n++) @(negedge clk);
                gap      = 1;
                mon_busy = 1'b0;
            end else begin
                mon_busy = 1'b1;
                e    = exp_q.pop_front();
                div  = int'(e[23:8]);
                got  = 8'd0;
                errs = 0;
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < div; k++) begin
                        if (i != 0 || k != 0) @(negedge clk);
                        lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : e[i-1];
                        if (tx !== lvl) errs++;
                        if (i >= 1 && i <= 8 && k == div / 2) got[i-1] = tx;
                    end
                end
                checks++;
                if (got !== e[7:0] || errs != 0 || (e[24] && gap != 0)) begin
                    failures++;
                    $display("FAIL frame got=0x%02h bad_samples=%0d gap=%0d required=0x%02h bad_samples=0 div=%0d no_gap=%0b",
                             got, errs, gap, e[7:0], div, e[24]);
                end
                gap      = 0;
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int blen;
        WE = 1'b0; A = A_TX; WD = 32'd0; rst_n = 1'b0; mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_irq", irq, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_check(A_ST,   32'h01, "reset_status");
        read_check(A_CTRL, 32'h00, "reset_ctrl");
        read_check(A_BAUD, 32'd16, "reset_baud");
        read_check(A_TX,   32'h00, "txdata_read");

        // 1: single 0xA5 frame at div 4
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'd1);
        expect_frame(8'hA5, 16'd4, 1'b0);
        bus_write(A_TX, 32'hA5);
        A = A_ST;
        blen = 0;
        for (int n = 0; n < 10 && !RD[2]; n++) @(negedge clk);
        while (RD[2] && blen < 1000) begin
            @(negedge clk);
            blen++;
        end
        check("t1_busy_len", blen, 40);
        wait_idle(200, "t1");
        check("t1_irq_masked", irq, 0);
        read_check(A_ST, 32'h09, "t1_status");

        // 2: overflow, W1C of ovf, then eight back-to-back frames
        bus_write(A_ST, 32'h18);
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(i));
        read_check(A_ST, 32'h12, "t2_full_ovf");
        bus_write(A_ST, 32'h10);
        read_check(A_ST, 32'h02, "t2_ovf_cleared");
        for (int i = 0; i < 8; i++) expect_frame(8'(i), 16'd4, i != 0);
        bus_write(A_CTRL, 32'd3);
        wait_idle(1000, "t2");
        check("t2_irq", irq, 1);
        read_check(A_ST, 32'h09, "t2_status");

        // 3: irq clear, irq after drain, masking with irq_en=0
        bus_write(A_ST, 32'h08);
        check("t3_irq_cleared", irq, 0);
        bus_write(A_BAUD, 32'd2);
        expect_frame(8'h55, 16'd2, 1'b0);
        bus_write(A_TX, 32'h55);
        wait_idle(200, "t3a");
        check("t3_irq_set", irq, 1);
        read_check(A_ST, 32'h09, "t3_status");
        bus_write(A_ST, 32'h08);
        check("t3_irq_w1c", irq, 0);
        bus_write(A_CTRL, 32'd1);
        expect_frame(8'h5A, 16'd2, 1'b0);
        bus_write(A_TX, 32'h5A);
        wait_idle(200, "t3b");
        check("t3_irq_masked", irq, 0);
        read_check(A_ST, 32'h09, "t3_pend_masked");

        // 4: div 0 acts as 1; divider change mid-frame applies to next frame
        bus_write(A_BAUD, 32'd0);
        expect_frame(8'hFF, 16'd1, 1'b0);
        bus_write(A_TX, 32'hFF);
        expect_frame(8'h3C, 16'd8, 1'b1);
        bus_write(A_TX, 32'h3C);
        read_check(A_BAUD, 32'd0, "t4_baud_zero");
        bus_write(A_BAUD, 32'd8);
        wait_idle(300, "t4");
        read_check(A_BAUD, 32'd8, "t4_baud_eight");

        // 5: asynchronous reset in the middle of a data bit
        bus_write(A_CTRL, 32'd3);
        check("t5_irq_before", irq, 1);
        mon_on = 1'b0;
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TX, 32'h00);
        repeat (8) @(posedge clk);
        #2;
        check("t5_tx_mid_data", tx, 0);
        rst_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1);
        check("t5_irq_async", irq, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_check(A_ST,   32'h01, "t5_status");
        read_check(A_BAUD, 32'd16, "t5_baud");
        read_check(A_CTRL, 32'd0,  "t5_ctrl");
        mon_on = 1'b1;

        // 6: push during pop at count 3, then disable en mid-frame
        bus_write(A_BAUD, 32'd2);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        expect_frame(8'h11, 16'd2, 1'b0);
        expect_frame(8'h22, 16'd2, 1'b1);
        bus_write(A_CTRL, 32'd1);
        bus_write(A_TX, 32'h44);
        for (int i = 0; i < 5; i++) bus_write(A_TX, 32'(8'hA0 + i));
        read_check(A_ST, 32'h06, "t6_full_no_ovf");
        bus_write(A_TX, 32'hEE);
        read_check(A_ST, 32'h16, "t6_ovf");
        repeat (22) @(posedge clk);
        #1;
        bus_write(A_CTRL, 32'd0);
        wait_idle(200, "t6_stop");
        read_check(A_ST, 32'h10, "t6_fifo_retained");
        bus_write(A_ST, 32'h10);
        expect_frame(8'h33, 16'd2, 1'b0);
        expect_frame(8'h44, 16'd2, 1'b1);
        for (int i = 0; i < 5; i++) expect_frame(8'(8'hA0 + i), 16'd2, 1'b1);
        bus_write(A_CTRL, 32'd1);
        wait_idle(400, "t6_resume");
        read_check(A_ST, 32'h09, "t6_status");

        check("leftover_frames", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
